// File: rtl/maze_pkg.sv
// Shared maze definitions: headings, motion FSM states and wall-bitmap index helpers.
// Also used by the scene and player renderers.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_WAIT,
    S_DECIDE,
    S_STEP,
    S_NOTIFY
  } state_t;

  // Bit of h_walls holding the top edge of cell (c,r).
  function automatic int h_idx(input int c, input int r, input int cols);
    return r * cols + c;
  endfunction

  // Bit of v_walls holding the left edge of cell (c,r).
  function automatic int v_idx(input int c, input int r, input int cols);
    return r * (cols + 1) + c;
  endfunction

  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/maze_mover_if.sv
// Mover-to-renderer link: sprite position/heading plus the step_valid/draw_busy handshake.
interface maze_mover_if #(
  parameter int PX_W = 9,
  parameter int PY_W = 9,
  parameter int CI_W = 8
);
  import maze_pkg::*;

  logic            draw_busy;
  logic [PX_W-1:0] pos_x;
  logic [PY_W-1:0] pos_y;
  dir_t            direction;
  logic            blocked;
  logic            step_valid;
  logic            cell_entered;
  logic [CI_W-1:0] cell_index;

  modport master (
    input  draw_busy,
    output pos_x, pos_y, direction, blocked, step_valid, cell_entered, cell_index
  );

  modport slave (
    output draw_busy,
    input  pos_x, pos_y, direction, blocked, step_valid, cell_entered, cell_index
  );

endinterface

// File: rtl/maze_wall_lookup.sv
// Combinational side check: is side dir of cell (col,row) open, counting walls and grid edges.
module maze_wall_lookup
  import maze_pkg::*;
#(
  parameter int COLS = 10,
  parameter int ROWS = 15,
  parameter int CX_W = $clog2(COLS),
  parameter int CY_W = $clog2(ROWS)
) (
  input  logic [CX_W-1:0]          col,
  input  logic [CY_W-1:0]          row,
  input  dir_t                     dir,
  input  logic [(ROWS+1)*COLS-1:0] h_walls,
  input  logic [ROWS*(COLS+1)-1:0] v_walls,
  output logic                     open
);

  localparam int HI_W = $clog2((ROWS + 1) * COLS);
  localparam int VI_W = $clog2(ROWS * (COLS + 1));

  int              c;
  int              r;
  logic [HI_W-1:0] hi_top;
  logic [HI_W-1:0] hi_bot;
  logic [VI_W-1:0] vi_left;
  logic [VI_W-1:0] vi_right;

  always_comb begin
    c        = 32'(col);
    r        = 32'(row);
    hi_top   = HI_W'(h_idx(c, r, COLS));
    hi_bot   = HI_W'(h_idx(c, r + 1, COLS));
    vi_left  = VI_W'(v_idx(c, r, COLS));
    vi_right = VI_W'(v_idx(c + 1, r, COLS));
    open     = 1'b0;
    // Edge terms keep the sprite inside the grid even with an empty wall map.
    case (dir)
      DIR_RIGHT: open = ~v_walls[vi_right] & (c < COLS - 1);
      DIR_DOWN:  open = ~h_walls[hi_bot]   & (r < ROWS - 1);
      DIR_LEFT:  open = ~v_walls[vi_left]  & (c > 0);
      DIR_UP:    open = ~h_walls[hi_top]   & (r > 0);
      default:   open = 1'b0;
    endcase
  end

endmodule

// File: rtl/maze_mover.sv
// Player motion engine: one pixel per tick across the maze grid, buffered turns applied
// at cell alignment, each completed step handed to the renderer.
module maze_mover
  import maze_pkg::*;
#(
  parameter int COLS      = 10,
  parameter int ROWS      = 15,
  parameter int CELL_LOG2 = 5,
  parameter int START_COL = 0,
  parameter int START_ROW = 0,
  parameter int START_DIR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               btn,
  input  logic [(ROWS+1)*COLS-1:0] h_walls,
  input  logic [ROWS*(COLS+1)-1:0] v_walls,
  input  logic                     tick,
  maze_mover_if.master             bus
);

  localparam int CX_W = $clog2(COLS);
  localparam int CY_W = $clog2(ROWS);
  localparam int PX_W = CX_W + CELL_LOG2;
  localparam int PY_W = CY_W + CELL_LOG2;
  localparam int CI_W = $clog2(ROWS * COLS);

  localparam logic [PX_W-1:0] START_X = PX_W'(START_COL * (2 ** CELL_LOG2));
  localparam logic [PY_W-1:0] START_Y = PY_W'(START_ROW * (2 ** CELL_LOG2));
  localparam dir_t            START_D = dir_t'(START_DIR[1:0]);

  state_t          state;
  logic [PX_W-1:0] pos_x;
  logic [PY_W-1:0] pos_y;
  dir_t            dir;
  dir_t            pend_dir;
  logic            pend_v;
  logic            blocked;
  logic            sv_q;
  logic            ce_q;
  logic [CI_W-1:0] cell_idx;

  logic [CX_W-1:0] col;
  logic [CY_W-1:0] row;
  logic            aligned;
  logic            open_pend;
  logic            open_cur;
  dir_t            btn_dir;
  logic [PX_W-1:0] nx;
  logic [PY_W-1:0] ny;
  logic            n_aligned;
  logic [CI_W-1:0] n_idx;

  assign col     = pos_x[PX_W-1:CELL_LOG2];
  assign row     = pos_y[PY_W-1:CELL_LOG2];
  assign aligned = ~|pos_x[CELL_LOG2-1:0] & ~|pos_y[CELL_LOG2-1:0];

  maze_wall_lookup #(.COLS(COLS), .ROWS(ROWS)) u_open_pend (
    .col(col), .row(row), .dir(pend_dir),
    .h_walls(h_walls), .v_walls(v_walls), .open(open_pend)
  );

  maze_wall_lookup #(.COLS(COLS), .ROWS(ROWS)) u_open_cur (
    .col(col), .row(row), .dir(dir),
    .h_walls(h_walls), .v_walls(v_walls), .open(open_cur)
  );

  always_comb begin
    btn_dir = DIR_UP;
    if (btn[0])      btn_dir = DIR_RIGHT;
    else if (btn[1]) btn_dir = DIR_DOWN;
    else if (btn[2]) btn_dir = DIR_LEFT;
  end

  always_comb begin
    nx = pos_x;
    ny = pos_y;
    case (dir)
      DIR_RIGHT: nx = pos_x + PX_W'(1);
      DIR_DOWN:  ny = pos_y + PY_W'(1);
      DIR_LEFT:  nx = pos_x - PX_W'(1);
      DIR_UP:    ny = pos_y - PY_W'(1);
      default:   nx = pos_x;
    endcase
    n_aligned = ~|nx[CELL_LOG2-1:0] & ~|ny[CELL_LOG2-1:0];
    n_idx     = CI_W'(32'(ny[PY_W-1:CELL_LOG2]) * 32'(COLS) + 32'(nx[PX_W-1:CELL_LOG2]));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_WAIT;
      pos_x    <= START_X;
      pos_y    <= START_Y;
      dir      <= START_D;
      pend_dir <= DIR_RIGHT;
      pend_v   <= 1'b0;
      blocked  <= 1'b0;
      sv_q     <= 1'b0;
      ce_q     <= 1'b0;
      cell_idx <= '0;
    end else begin
      sv_q <= 1'b0;
      ce_q <= 1'b0;
      case (state)
        S_WAIT: begin
          if (tick && !bus.draw_busy) begin
            if (aligned) begin
              state <= S_DECIDE;
            end else begin
              // Reversal needs no wall check: the cell just left is known to be open.
              if (pend_v && pend_dir == reverse(dir)) begin
                dir     <= pend_dir;
                pend_v  <= 1'b0;
                blocked <= 1'b0;
              end
              state <= S_STEP;
            end
          end
        end
        S_DECIDE: begin
          if (pend_v && open_pend) begin
            dir     <= pend_dir;
            pend_v  <= 1'b0;
            blocked <= 1'b0;
          end else begin
            blocked <= ~open_cur;
          end
          state <= S_STEP;
        end
        S_STEP: begin
          if (blocked) begin
            state <= S_WAIT;
          end else begin
            pos_x <= nx;
            pos_y <= ny;
            sv_q  <= 1'b1;
            ce_q  <= n_aligned;
            if (n_aligned) cell_idx <= n_idx;
            state <= S_NOTIFY;
          end
        end
        S_NOTIFY: state <= S_WAIT;
        default:  state <= S_WAIT;
      endcase
      // A new press overrides a clear made by a turn applied on the same edge.
      if (|btn) begin
        pend_dir <= btn_dir;
        pend_v   <= 1'b1;
      end
    end
  end

  // Pulses are masked by rst so a reset landing on the notify cycle emits nothing.
  assign bus.pos_x        = pos_x;
  assign bus.pos_y        = pos_y;
  assign bus.direction    = dir;
  assign bus.blocked      = blocked;
  assign bus.step_valid   = sv_q & rst;
  assign bus.cell_entered = ce_q & rst;
  assign bus.cell_index   = cell_idx;

endmodule

// File: tb/tb_maze_mover.sv
// Bench for maze_mover: default 10x15 grid and a 4x3 grid with 8-px cells, both checked
// every cycle against a timestamp-based reference model, plus directed scenarios.
module tb_maze_mover;
  import maze_pkg::*;

  localparam int C0 = 10, R0 = 15, L0 = 5;
  localparam int C1 = 4,  R1 = 3,  L1 = 3;
  localparam longint NEVER = 64'h3fff_ffff_ffff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   btn;
  logic         tick;
  logic         busy;
  logic [255:0] hwm [2];
  logic [255:0] vwm [2];

  maze_mover_if #(.PX_W(9), .PY_W(9), .CI_W(8)) bus0 ();
  maze_mover_if #(.PX_W(5), .PY_W(5), .CI_W(4)) bus1 ();
  assign bus0.draw_busy = busy;
  assign bus1.draw_busy = busy;

  maze_mover #(.COLS(C0), .ROWS(R0), .CELL_LOG2(L0),
               .START_COL(0), .START_ROW(0), .START_DIR(2)) dut0 (
    .clk(clk), .rst(rst), .btn(btn),
    .h_walls(hwm[0][(R0+1)*C0-1:0]), .v_walls(vwm[0][R0*(C0+1)-1:0]),
    .tick(tick), .bus(bus0)
  );

  maze_mover #(.COLS(C1), .ROWS(R1), .CELL_LOG2(L1),
               .START_COL(0), .START_ROW(0), .START_DIR(2)) dut1 (
    .clk(clk), .rst(rst), .btn(btn),
    .h_walls(hwm[1][(R1+1)*C1-1:0]), .v_walls(vwm[1][R1*(C1+1)-1:0]),
    .tick(tick), .bus(bus1)
  );

  // Reference model: pixel coordinates plus the cycle numbers at which the pending
  // decision and the move of the current tick take effect.
  int     cols [2] = '{C0, C1};
  int     rows [2] = '{R0, R1};
  int     lg   [2] = '{L0, L1};
  int     px [2], py [2], mdir [2], pd [2], eci [2];
  bit     pv [2], blk [2], esv [2], ece [2];
  longint free_t [2], dec_t [2], mov_t [2];
  longint cyc = 0;

  int n_chk = 0;
  int n_err = 0;
  int nsv0  = 0;
  int nce0  = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit open_m(input int i, input int c, input int r, input int d);
    int cc = cols[i];
    int rr = rows[i];
    case (d)
      0:       return !vwm[i][r*(cc+1)+c+1] && c < cc - 1;
      1:       return !hwm[i][(r+1)*cc+c]   && r < rr - 1;
      2:       return !vwm[i][r*(cc+1)+c]   && c > 0;
      default: return !hwm[i][r*cc+c]       && r > 0;
    endcase
  endfunction

  task automatic model_edge(input int i);
    int s = 1 << lg[i];
    bit al;
    esv[i] = 0;
    ece[i] = 0;
    if (!rst) begin
      px[i] = 0; py[i] = 0; mdir[i] = 2; pv[i] = 0; pd[i] = 0; blk[i] = 0; eci[i] = 0;
      free_t[i] = cyc + 1; dec_t[i] = -1; mov_t[i] = -1;
      return;
    end
    al = (px[i] % s == 0) && (py[i] % s == 0);
    if (cyc == dec_t[i]) begin
      if (pv[i] && open_m(i, px[i] / s, py[i] / s, pd[i])) begin
        mdir[i] = pd[i];
        pv[i]   = 0;
      end
      blk[i] = !open_m(i, px[i] / s, py[i] / s, mdir[i]);
    end
    if (cyc == mov_t[i]) begin
      if (blk[i]) begin
        free_t[i] = cyc + 1;
      end else begin
        case (mdir[i])
          0:       px[i] += 1;
          1:       py[i] += 1;
          2:       px[i] -= 1;
          default: py[i] -= 1;
        endcase
        esv[i] = 1;
        if (px[i] % s == 0 && py[i] % s == 0) begin
          ece[i] = 1;
          eci[i] = (py[i] / s) * cols[i] + px[i] / s;
        end
        free_t[i] = cyc + 2;
      end
      mov_t[i] = -1;
    end else if (cyc >= free_t[i] && tick && !busy) begin
      free_t[i] = NEVER;
      if (al) begin
        dec_t[i] = cyc + 1;
        mov_t[i] = cyc + 2;
      end else begin
        if (pv[i] && pd[i] == (mdir[i] ^ 2)) begin
          mdir[i] = pd[i];
          pv[i]   = 0;
          blk[i]  = 0;
        end
        mov_t[i] = cyc + 1;
      end
    end
    if (btn != 4'd0) begin
      pd[i] = btn[0] ? 0 : btn[1] ? 1 : btn[2] ? 2 : 3;
      pv[i] = 1;
    end
  endtask

  task automatic compare_all();
    check("x0",   bus0.pos_x, px[0]);
    check("y0",   bus0.pos_y, py[0]);
    check("dir0", int'(bus0.direction), mdir[0]);
    check("blk0", bus0.blocked, blk[0]);
    check("sv0",  bus0.step_valid, esv[0]);
    check("ce0",  bus0.cell_entered, ece[0]);
    if (ece[0]) check("ci0", bus0.cell_index, eci[0]);
    check("x1",   bus1.pos_x, px[1]);
    check("y1",   bus1.pos_y, py[1]);
    check("dir1", int'(bus1.direction), mdir[1]);
    check("blk1", bus1.blocked, blk[1]);
    check("sv1",  bus1.step_valid, esv[1]);
    check("ce1",  bus1.cell_entered, ece[1]);
    if (ece[1]) check("ci1", bus1.cell_index, eci[1]);
    if (bus0.step_valid)   nsv0++;
    if (bus0.cell_entered) nce0++;
  endtask

  task automatic step(input logic [3:0] b, input logic tk, input logic bz);
    btn  = b;
    tick = tk;
    busy = bz;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick_gap(input logic [3:0] b);
    step(b, 1'b1, 1'b0);
    repeat (4) step(b, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; btn = '0; tick = 1'b0; busy = 1'b0;
    hwm[0] = '0; hwm[1] = '0; vwm[0] = '0; vwm[1] = '0;
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    check("rst_x", bus0.pos_x, 0);
    check("rst_dir", int'(bus0.direction), 2);
    check("rst_ci", bus0.cell_index, 0);
    rst = 1'b1;

    // Heading left from the left edge: never moves.
    nsv0 = 0;
    repeat (32) tick_gap(4'd0);
    check("t1_x", bus0.pos_x, 0);
    check("t1_blk", bus0.blocked, 1);
    check("t1_sv", nsv0, 0);

    // One-cycle press of +x then a full cell of ticks.
    nsv0 = 0; nce0 = 0;
    step(4'b0001, 1'b0, 1'b0);
    repeat (32) tick_gap(4'd0);
    check("t2_x", bus0.pos_x, 32);
    check("t2_y", bus0.pos_y, 0);
    check("t2_sv", nsv0, 32);
    check("t2_ce", nce0, 1);
    check("t2_ci", bus0.cell_index, 1);
    check("t2_x_small", bus1.pos_x, 24);
    check("t2_blk_small", bus1.blocked, 1);

    // Mid-cell reversal at pos_x=40 takes effect on the next tick, 2-cycle latency.
    repeat (8) tick_gap(4'd0);
    check("t4_x40", bus0.pos_x, 40);
    step(4'b0100, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    check("t4_sv", bus0.step_valid, 1);
    check("t4_x", bus0.pos_x, 39);
    check("t4_dir", int'(bus0.direction), 2);

    // Ticks while the renderer is busy are dropped.
    step(4'd0, 1'b0, 1'b0);
    nsv0 = 0;
    repeat (10) begin
      step(4'd0, 1'b1, 1'b1);
      repeat (4) step(4'd0, 1'b0, 1'b1);
    end
    check("t5_x", bus0.pos_x, 39);
    check("t5_sv", nsv0, 0);
    step(4'd0, 1'b1, 1'b0);
    step(4'd0, 1'b0, 1'b0);
    check("t5_sv_after", bus0.step_valid, 1);
    check("t5_x_after", bus0.pos_x, 38);

    // Reset landing on the notify cycle.
    step(4'd0, 1'b0, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5 && !esv[0]; k++) step(4'd0, 1'b0, 1'b0);
    check("t6_pre_sv", bus0.step_valid, 1);
    rst = 1'b0;
    #1;
    check("t6_sv", bus0.step_valid, 0);
    check("t6_ce", bus0.cell_entered, 0);
    step(4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    check("t6_x", bus0.pos_x, 0);
    check("t6_dir", int'(bus0.direction), 2);

    // Wall on the right of cell (0,0) holds a +x request until it is cleared.
    vwm[0][1] = 1'b1;
    repeat (3) tick_gap(4'b0001);
    check("t3_dir", int'(bus0.direction), 2);
    check("t3_blk", bus0.blocked, 1);
    check("t3_x", bus0.pos_x, 0);
    vwm[0][1] = 1'b0;
    tick_gap(4'b0001);
    check("t3_dir_after", int'(bus0.direction), 0);
    check("t3_x_after", bus0.pos_x, 1);

    // Random play with random wall maps and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] b;
      int r;
      if (n % 250 == 0) begin
        for (int j = 0; j < 256; j++) begin
          hwm[0][j] = ($urandom % 5 == 0);
          vwm[0][j] = ($urandom % 5 == 0);
          hwm[1][j] = ($urandom % 5 == 0);
          vwm[1][j] = ($urandom % 5 == 0);
        end
      end
      r = int'($urandom % 16);
      b = (r == 0) ? 4'(1 << ($urandom % 4)) : (r == 1) ? 4'($urandom) : 4'd0;
      rst = ($urandom % 800 != 0);
      step(b, ($urandom % 3 == 0), ($urandom % 5 == 0));
      rst = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
